// File: rtl/vld_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : vld_mem_if
//  Description : Word-read memory port used by the vector load unit.
//                One request can be outstanding at a time. The response comes
//                back on mem_rvalid/mem_rdata and its data is little-endian.
//  Signals     : mem_req    - read request (master -> slave)
//                mem_addr   - byte address of the requested word (master -> slave)
//                mem_ready  - request accepted this cycle (slave -> master)
//                mem_rvalid - read response valid (slave -> master)
//                mem_rdata  - read response data (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vld_mem_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/vld_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vld_unit
//  Description : Unit-stride vector load. Fetches vl elements of SEW bits,
//                starting at base_addr_i, one 32-bit word at a time. Every
//                group of four words is packed into a 128-bit register-file
//                write to vd, vd+1, ... (mod 32). Bytes past the end of the
//                vector in the last register are written as zero.
//  Ports       : clk, rst_n       - clock, asynchronous active-low reset
//                start_i          - command strobe, sampled only when idle
//                vd_i             - first destination register
//                base_addr_i      - byte address of element 0
//                vl_i             - element count (0..256)
//                vtype_i          - [6] valid, [5:3] SEW code (8/16/32)
//                mem              - word-read memory port (master side)
//                wen_o/wa_o/wd_o  - register-file write port
//                busy_o           - high whenever not idle
//                done_o           - one-cycle completion pulse
//                err_o            - command rejected, valid with done_o
//  Revision    : 1.0 - initial release
// ============================================================================
module vld_unit (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         start_i,
    input  wire logic [4:0]   vd_i,
    input  wire logic [31:0]  base_addr_i,
    input  wire logic [8:0]   vl_i,
    input  wire logic [6:0]   vtype_i,
    vld_mem_if.master         mem,
    output logic              wen_o,
    output logic [4:0]        wa_o,
    output logic [127:0]      wd_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     vd_q, vd_d;
    logic [31:0]    base_q, base_d;
    logic [8:0]     vl_q, vl_d;
    logic           vvalid_q, vvalid_d;
    logic [2:0]     sew_q, sew_d;
    logic [8:0]     k_q, k_d;          // words fetched so far
    logic [6:0]     r_q, r_d;          // registers written so far
    logic [127:0]   buf_q, buf_d;      // assembly buffer for one register
    logic           err_q, err_d;

    // Operand-derived sizes; only meaningful once the SEW code has passed
    // the legality check, which is the only time they are consulted.
    logic [10:0]    w_bytes;
    logic [11:0]    w_bytes_p3;
    logic [8:0]     w_words;
    logic [8:0]     w_k_next;
    logic [127:0]   w_mask;
    logic [10:0]    w_byte_idx;
    logic           w_bad_cmd;

    assign w_bytes    = 11'(vl_q) << sew_q[1:0];
    assign w_bytes_p3 = 12'(w_bytes) + 12'd3;
    assign w_words    = w_bytes_p3[10:2];
    assign w_k_next   = k_q + 9'd1;
    assign w_bad_cmd  = !vvalid_q || (sew_q > 3'b010) || (base_q[1:0] != 2'b00);

    // Byte-enable for the register being written: keep byte j only if its
    // position in the whole vector (16*r + j) lies below the byte count.
    always_comb begin
        w_mask     = '0;
        w_byte_idx = '0;
        for (int j = 0; j < 16; j++) begin
            w_byte_idx       = {r_q, 4'b0000} + 11'(j);
            w_mask[8*j +: 8] = (w_byte_idx < w_bytes) ? 8'hFF : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vd_q     <= '0;
            base_q   <= '0;
            vl_q     <= '0;
            vvalid_q <= 1'b0;
            sew_q    <= '0;
            k_q      <= '0;
            r_q      <= '0;
            buf_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vd_q     <= vd_d;
            base_q   <= base_d;
            vl_q     <= vl_d;
            vvalid_q <= vvalid_d;
            sew_q    <= sew_d;
            k_q      <= k_d;
            r_q      <= r_d;
            buf_q    <= buf_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vd_d         = vd_q;
        base_d       = base_q;
        vl_d         = vl_q;
        vvalid_d     = vvalid_q;
        sew_d        = sew_q;
        k_d          = k_q;
        r_d          = r_q;
        buf_d        = buf_q;
        err_d        = err_q;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        wen_o        = 1'b0;
        wa_o         = '0;
        wd_o         = '0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        busy_o       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    vd_d     = vd_i;
                    base_d   = base_addr_i;
                    vl_d     = vl_i;
                    vvalid_d = vtype_i[6];
                    sew_d    = vtype_i[5:3];
                    k_d      = '0;
                    r_d      = '0;
                    buf_d    = '0;
                    err_d    = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_bad_cmd) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (vl_q == 9'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = base_q + {21'd0, k_q, 2'b00};
                if (mem.mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    buf_d[{k_q[1:0], 5'b00000} +: 32] = mem.mem_rdata;
                    k_d = w_k_next;
                    // A register is complete every fourth word or at the end.
                    if ((w_k_next[1:0] == 2'b00) || (w_k_next == w_words)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_WRITE: begin
                wen_o   = 1'b1;
                wa_o    = vd_q + r_q[4:0];
                wd_o    = buf_q & w_mask;
                buf_d   = '0;
                r_d     = r_q + 7'd1;
                state_d = (k_q < w_words) ? S_REQ : S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_vld_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vld_unit
//  Description : Directed self-checking bench for vld_unit. A simple memory
//                returns data = address one cycle after each accepted request;
//                a negedge monitor logs requests, writes and done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vld_unit;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [4:0]   vd_i;
    logic [31:0]  base_addr_i;
    logic [8:0]   vl_i;
    logic [6:0]   vtype_i;
    logic         wen_o;
    logic [4:0]   wa_o;
    logic [127:0] wd_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    logic         ready_en;
    logic         rsp_en;
    logic         rv_auto;
    logic [31:0]  rd_auto;
    logic         rv_man;
    logic [31:0]  rd_man;

    int vectors;
    int miscompares;

    vld_mem_if u_if ();

    assign u_if.mem_ready  = ready_en;
    assign u_if.mem_rvalid = rv_auto | rv_man;
    assign u_if.mem_rdata  = rv_man ? rd_man : rd_auto;

    vld_unit u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .vd_i        (vd_i),
        .base_addr_i (base_addr_i),
        .vl_i        (vl_i),
        .vtype_i     (vtype_i),
        .mem         (u_if.master),
        .wen_o       (wen_o),
        .wa_o        (wa_o),
        .wd_o        (wd_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: respond one cycle after acceptance with data equal to address.
    always @(posedge clk) begin
        rv_auto <= rsp_en && u_if.mem_req && u_if.mem_ready;
        rd_auto <= u_if.mem_addr;
    end

    // Monitor state
    int           cyc, n_req, n_wr, n_done, done_cyc, busy_cyc, dbl_done;
    int           err_stray, unstable, stall_cyc;
    logic [31:0]  req_addr [64];
    logic [4:0]   wr_wa [16];
    logic [127:0] wr_wd [16];
    int           wr_cyc [16];
    logic         done_err;
    logic         p_req, p_ready, p_done, p_busy;
    logic [31:0]  p_addr;

    initial begin
        cyc = 0; n_req = 0; n_wr = 0; n_done = 0; done_cyc = 0; busy_cyc = 0;
        dbl_done = 0; err_stray = 0; unstable = 0; stall_cyc = 0; done_err = 1'b0;
        p_req = 1'b0; p_ready = 1'b0; p_done = 1'b0; p_busy = 1'b0; p_addr = '0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (u_if.mem_req && u_if.mem_ready) begin
            if (n_req < 64) req_addr[n_req] = u_if.mem_addr;
            n_req = n_req + 1;
        end
        if (wen_o) begin
            if (n_wr < 16) begin
                wr_wa[n_wr]  = wa_o;
                wr_wd[n_wr]  = wd_o;
                wr_cyc[n_wr] = cyc;
            end
            n_wr = n_wr + 1;
        end
        if (done_o) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
            done_err = err_o;
            if (p_done) dbl_done = dbl_done + 1;
        end
        if (err_o && !done_o) err_stray = err_stray + 1;
        if (p_req && !p_ready) begin
            if (!u_if.mem_req || (u_if.mem_addr != p_addr)) unstable = unstable + 1;
            else stall_cyc = stall_cyc + 1;
        end
        if (busy_o && !p_busy) busy_cyc = cyc;
        p_req   = u_if.mem_req;
        p_ready = u_if.mem_ready;
        p_addr  = u_if.mem_addr;
        p_done  = done_o;
        p_busy  = busy_o;
    end

    int r0, w0, d0;

    task automatic pulse_start(input logic [4:0] vd, input logic [31:0] base,
                               input logic [8:0] vl, input logic [6:0] vt);
        r0 = n_req; w0 = n_wr; d0 = n_done;
        @(posedge clk); #1;
        start_i = 1'b1; vd_i = vd; base_addr_i = base; vl_i = vl; vtype_i = vt;
        @(posedge clk); #1;
        // Scramble operands after capture; they must have no effect.
        start_i = 1'b0; vd_i = 5'h15; base_addr_i = 32'hFFFF_FFF0; vl_i = 9'h1FF; vtype_i = 7'h00;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && n_done == d0; i++) @(negedge clk);
        #1;
        if (n_done == d0) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: done count %0d, required %0d", name, n_done - d0, 1);
        end
    endtask

    task automatic run_cmd(input string name, input logic [4:0] vd, input logic [31:0] base,
                           input logic [8:0] vl, input logic [6:0] vt);
        pulse_start(vd, base, vl, vt);
        wait_done(name);
    endtask

    task automatic check_basic_result(input string name);
        vectors++;
        if (n_req - r0 !== 4) begin
            miscompares++; $display("FAIL %s_nreq: got %0d, required 4", name, n_req - r0);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (req_addr[r0+i] !== 32'h100 + 32'(4*i)) begin
                miscompares++;
                $display("FAIL %s_addr%0d: got %h, required %h", name, i, req_addr[r0+i], 32'h100 + 32'(4*i));
            end
        end
        vectors++;
        if (n_wr - w0 !== 1) begin
            miscompares++; $display("FAIL %s_nwr: got %0d, required 1", name, n_wr - w0);
        end
        vectors++;
        if (wr_wa[w0] !== 5'd3) begin
            miscompares++; $display("FAIL %s_wa: got %0d, required 3", name, wr_wa[w0]);
        end
        vectors++;
        if (wr_wd[w0] !== 128'h0000010C_00000108_00000104_00000100) begin
            miscompares++; $display("FAIL %s_wd: got %h, required %h", name, wr_wd[w0],
                                    128'h0000010C_00000108_00000104_00000100);
        end
        vectors++;
        if (done_cyc - wr_cyc[w0] !== 1) begin
            miscompares++; $display("FAIL %s_done_lat: got %0d, required 1", name, done_cyc - wr_cyc[w0]);
        end
        vectors++;
        if (done_err !== 1'b0) begin
            miscompares++; $display("FAIL %s_err: got %b, required 0", name, done_err);
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({busy_o, done_o, err_o, wen_o, u_if.mem_req} !== 5'b0) begin
            miscompares++; $display("FAIL reset_ctrl: got %b, required 00000",
                                    {busy_o, done_o, err_o, wen_o, u_if.mem_req});
        end
        vectors++;
        if ({u_if.mem_addr, wa_o, wd_o} !== 165'd0) begin
            miscompares++; $display("FAIL reset_data: addr %h wa %h wd %h, required all zero",
                                    u_if.mem_addr, wa_o, wd_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        run_cmd("basic", 5'd3, 32'h100, 9'd4, 7'h50);
        check_basic_result("basic");
    endtask

    task automatic test_wrap();
        run_cmd("wrap", 5'd31, 32'h200, 9'd20, 7'h40);
        vectors++;
        if ((n_req - r0 !== 5) || (n_wr - w0 !== 2)) begin
            miscompares++; $display("FAIL wrap_counts: req %0d wr %0d, required 5 2", n_req - r0, n_wr - w0);
        end
        vectors++;
        if ({wr_wa[w0], wr_wa[w0+1]} !== {5'd31, 5'd0}) begin
            miscompares++; $display("FAIL wrap_wa: got %0d %0d, required 31 0", wr_wa[w0], wr_wa[w0+1]);
        end
        vectors++;
        if (wr_wd[w0] !== 128'h0000020C_00000208_00000204_00000200) begin
            miscompares++; $display("FAIL wrap_wd0: got %h", wr_wd[w0]);
        end
        vectors++;
        if (wr_wd[w0+1] !== 128'h00000210) begin
            miscompares++; $display("FAIL wrap_wd1: got %h, required %h", wr_wd[w0+1], 128'h210);
        end
    endtask

    task automatic test_tail();
        // 18 bytes: last register keeps only bytes 16..17 of word 0x12340010.
        run_cmd("tail", 5'd5, 32'h1234_0000, 9'd18, 7'h40);
        vectors++;
        if ({wr_wa[w0], wr_wa[w0+1]} !== {5'd5, 5'd6}) begin
            miscompares++; $display("FAIL tail_wa: got %0d %0d, required 5 6", wr_wa[w0], wr_wa[w0+1]);
        end
        vectors++;
        if (wr_wd[w0+1] !== 128'h0010) begin
            miscompares++; $display("FAIL tail_wd1: got %h, required %h", wr_wd[w0+1], 128'h0010);
        end
    endtask

    task automatic test_sew16();
        // 6 halfwords = 12 bytes = 3 words; fourth word slot stays zero.
        run_cmd("sew16", 5'd7, 32'h100, 9'd6, 7'h48);
        vectors++;
        if ((n_req - r0 !== 3) || (n_wr - w0 !== 1)) begin
            miscompares++; $display("FAIL sew16_counts: req %0d wr %0d, required 3 1", n_req - r0, n_wr - w0);
        end
        vectors++;
        if (wr_wd[w0] !== 128'h00000000_00000108_00000104_00000100) begin
            miscompares++; $display("FAIL sew16_wd: got %h", wr_wd[w0]);
        end
    endtask

    task automatic test_zero_len();
        run_cmd("zlen", 5'd1, 32'h100, 9'd0, 7'h50);
        vectors++;
        if ((n_req - r0 !== 0) || (n_wr - w0 !== 0) || (done_err !== 1'b0)) begin
            miscompares++; $display("FAIL zlen_result: req %0d wr %0d err %b, required 0 0 0",
                                    n_req - r0, n_wr - w0, done_err);
        end
        vectors++;
        if (done_cyc - busy_cyc !== 1) begin
            miscompares++; $display("FAIL zlen_latency: got %0d, required 1", done_cyc - busy_cyc);
        end
    endtask

    task automatic test_errors();
        logic [6:0]  vt_tab   [3] = '{7'h00, 7'h58, 7'h50};
        logic [31:0] base_tab [3] = '{32'h100, 32'h100, 32'h102};
        for (int i = 0; i < 3; i++) begin
            run_cmd("err", 5'd2, base_tab[i], 9'd4, vt_tab[i]);
            vectors++;
            if ((done_err !== 1'b1) || (n_req - r0 !== 0) || (n_wr - w0 !== 0)) begin
                miscompares++; $display("FAIL err_case%0d: err %b req %0d wr %0d, required 1 0 0",
                                        i, done_err, n_req - r0, n_wr - w0);
            end
        end
        vectors++;
        if (err_stray !== 0) begin
            miscompares++; $display("FAIL err_only_with_done: stray cycles %0d, required 0", err_stray);
        end
    endtask

    task automatic test_stall();
        int s0;
        s0 = stall_cyc;
        ready_en = 1'b0;
        pulse_start(5'd3, 32'h100, 9'd4, 7'h50);
        repeat (2) @(posedge clk);
        #1;
        // Start while busy with different operands: must be ignored.
        start_i = 1'b1; vd_i = 5'd20; base_addr_i = 32'h800; vl_i = 9'd1; vtype_i = 7'h50;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_en = 1'b1;
        wait_done("stall");
        vectors++;
        if ((stall_cyc - s0 < 5) || (unstable !== 0)) begin
            miscompares++; $display("FAIL stall_hold: stalls %0d unstable %0d, required >=5 0",
                                    stall_cyc - s0, unstable);
        end
        check_basic_result("stall");
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if ((n_done - d0 !== 1) || (busy_o !== 1'b0) || (dbl_done !== 0)) begin
            miscompares++; $display("FAIL stall_ignored_start: dones %0d busy %b dbl %0d, required 1 0 0",
                                    n_done - d0, busy_o, dbl_done);
        end
    endtask

    task automatic test_reset_mid();
        rsp_en = 1'b0;
        pulse_start(5'd3, 32'h100, 9'd4, 7'h50);
        for (int i = 0; i < 20 && n_req == r0; i++) @(negedge clk);
        @(posedge clk); #2;
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_busy_before: got %b, required 1", busy_o);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy_o, u_if.mem_req, wen_o, done_o, err_o, u_if.mem_addr, wa_o, wd_o} !== 170'd0) begin
            miscompares++; $display("FAIL rstmid_outputs: busy %b req %b wen %b addr %h, required all zero",
                                    busy_o, u_if.mem_req, wen_o, u_if.mem_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv_man = 1'b1; rd_man = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rv_man = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ((n_wr - w0 !== 0) || (n_done - d0 !== 0) || (busy_o !== 1'b0)) begin
            miscompares++; $display("FAIL rstmid_late_rvalid: wr %0d done %0d busy %b, required 0 0 0",
                                    n_wr - w0, n_done - d0, busy_o);
        end
        rsp_en = 1'b1;
        run_cmd("rstmid_after", 5'd3, 32'h100, 9'd4, 7'h50);
        check_basic_result("rstmid_after");
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start_i = 1'b0; vd_i = '0; base_addr_i = '0; vl_i = '0; vtype_i = '0;
        ready_en = 1'b1; rsp_en = 1'b1; rv_man = 1'b0; rd_man = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_tail();
        test_sew16();
        test_zero_len();
        test_errors();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vld_unit.md
VLD_UNIT -- requirements
Module: vld_unit

Interface
REQ-001: clk  in  1  single clock; all state updates on rising edge.
REQ-002: rst  in  1  reset; asynchronous, active-low.
REQ-003: start  in  1  load command strobe; sampled only in IDLE.
REQ-004: vd  in  5  first destination vector register.
REQ-005: base_addr  in  32  byte address of element 0.
REQ-006: vl  in  9  element count (0..256).
REQ-007: vtype  in  7  bit6 = valid, bits5:3 = SEW code (000=8, 001=16, 010=32).
REQ-008: mem_req / mem_addr  out  1 / 32  word read request and its byte address.
REQ-009: mem_ready  in  1  request accepted this cycle.
REQ-010: mem_rvalid / mem_rdata  in  1 / 32  read response and its data, little-endian.
REQ-011: wen / wa / wd  out  1 / 5 / 128  register-file write port.
REQ-012: busy  out  1  high in every state except IDLE.
REQ-013: done  out  1  one-cycle completion pulse.
REQ-014: err  out  1  valid only with done; command rejected.

Function
REQ-015: Captures vd, base_addr, vl, vtype on start in IDLE; start while busy is ignored.
REQ-016: Operands are held internally; input changes after capture have no effect.
REQ-017: Byte count B = vl * SEW/8; word count W = ceil(B/4); register count R = ceil(B/16).
REQ-018: FSM states: IDLE, CHECK, REQ, WAIT, WRITE, DONE.
REQ-019: IDLE -> CHECK on start.
REQ-020: CHECK -> DONE with err=1 if vtype[6]=0, SEW code > 010, or base_addr[1:0] != 0; no memory requests or writes are issued.
REQ-021: CHECK -> DONE with err=0 if vl=0; no requests or writes are issued.
REQ-022: Otherwise CHECK -> REQ.
REQ-023: REQ: mem_req=1 and mem_addr = base + 4*k for word k; mem_addr is held stable until mem_ready; advances to WAIT in the cycle mem_ready=1.
REQ-024: Exactly one request is outstanding at a time; mem_rvalid outside WAIT is ignored.
REQ-025: WAIT: on mem_rvalid, mem_rdata is stored into buffer bits [32*(k mod 4)+31 : 32*(k mod 4)] and k increments.
REQ-026: WAIT exits to WRITE if k mod 4 = 0 or k = W, else to REQ.
REQ-027: Bytes at positions >= B within the last register are written as zero (tail zeroed).
REQ-028: Unfetched words of a partial register are written as zero.
REQ-029: WRITE: wen=1 for exactly one cycle, wa = (vd + r) mod 32 for register r, wd = buffer.
REQ-030: After WRITE the buffer is cleared and r increments.
REQ-031: WRITE exits to REQ if k < W, else to DONE.
REQ-032: DONE: done=1 for one cycle, then IDLE; a start in the DONE cycle is ignored.
REQ-033: wen, mem_req, done and err are 0 in all states not named above.
REQ-034: Minimum latency per word is 2 cycles (REQ + WAIT); per register, 1 extra WRITE cycle.

Reset
REQ-035: Assertion of rst in any state takes effect immediately (asynchronously) and forces IDLE, k=r=0, buffer=0, and mem_req=wen=busy=done=err=0, mem_addr=0, wa=0, wd=0.
REQ-036: A transaction interrupted by reset is abandoned; a late mem_rvalid after reset is ignored.

Verification
REQ-037: vd=3, base=0x100, vl=4, SEW32, memory word = address, ready and rvalid immediate -> 4 requests to 0x100..0x10C, one write wa=3, wd=0x0000010C_00000108_00000104_00000100, done 1 cycle later, err=0.
REQ-038: vd=31, vl=20, SEW8 -> W=5, R=2; writes to wa=31 then wa=0; second register holds bytes 16..19 with upper 96 bits zero.
REQ-039: vl=0 with valid vtype -> done one cycle after CHECK, err=0, no mem_req, no wen.
REQ-040: vtype=0x00, or SEW code 011, or base=0x102 -> done with err=1, no mem_req, no wen.
REQ-041: mem_ready held low for 5 cycles -> mem_req and mem_addr remain stable throughout; result matches REQ-037; a start pulse issued while busy is ignored.
REQ-042: rst asserted during WAIT, then mem_rvalid arrives -> outputs zero immediately; no wen; a new start after release completes normally.
